// File: rtl/config_loader_pkg.sv
// Shared types and constants for the configuration chain loader.
package config_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2
  } loader_state_t;

  localparam int DEF_CHAIN_LENGTH = 100;
  localparam int DEF_WORD_WIDTH   = 8;
  localparam int DEF_CLEAR_CYCLES = 2;

  typedef struct packed {
    logic [31:0] words;
    logic [31:0] last_bits;
  } chain_geom_t;

  // Words needed for the chain and bits taken from the final word (a full word when it divides evenly).
  function automatic chain_geom_t chain_geom(input int chain_length, input int word_width);
    chain_geom_t g;
    g.words     = 32'((chain_length + word_width - 1) / word_width);
    g.last_bits = ((chain_length % word_width) == 0) ? 32'(word_width)
                                                     : 32'(chain_length % word_width);
    return g;
  endfunction

endpackage

// File: rtl/config_word_serializer.sv
// Holding register that takes bitstream words over valid/ready and emits them MSB first,
// one registered bit per cycle; the final word is truncated to LAST_BITS.
module config_word_serializer #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_WORDS  = 13,
  parameter int LAST_BITS  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  active,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  bit_out,
  output logic                  bit_valid
);

  localparam int CW = $clog2(WORD_WIDTH + 1);
  localparam int NW = $clog2(NUM_WORDS + 1);
  localparam logic [CW-1:0] FULL_N   = CW'(WORD_WIDTH);
  localparam logic [CW-1:0] LAST_N   = CW'(LAST_BITS);
  localparam logic [NW-1:0] WORDS_N  = NW'(NUM_WORDS);
  localparam logic [NW-1:0] LAST_IDX = NW'(NUM_WORDS - 1);

  logic [WORD_WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]         left_q, left_d;
  logic [NW-1:0]         accepted_q, accepted_d;
  logic                  ready_q, ready_d;
  logic                  bit_q, bit_d;
  logic                  bit_valid_q, bit_valid_d;
  logic                  take;

  always_comb begin
    take       = word_valid && ready_q;
    hold_d     = hold_q;
    left_d     = left_q;
    accepted_d = accepted_q;
    if (!active) begin
      hold_d     = '0;
      left_d     = '0;
      accepted_d = '0;
    end else if (take) begin
      hold_d     = word_data;
      left_d     = (accepted_q == LAST_IDX) ? LAST_N : FULL_N;
      accepted_d = accepted_q + NW'(1);
    end else if (left_q != '0) begin
      hold_d = hold_q << 1;
      left_d = left_q - CW'(1);
    end
    // Ready while the next cycle shifts the last bit (or nothing), so words stream without a bubble.
    ready_d     = active && (left_d <= CW'(1)) && (accepted_d != WORDS_N);
    bit_valid_d = (left_d != '0);
    bit_d       = bit_valid_d && hold_d[WORD_WIDTH-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q      <= '0;
      left_q      <= '0;
      accepted_q  <= '0;
      ready_q     <= 1'b0;
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      left_q      <= left_d;
      accepted_q  <= accepted_d;
      ready_q     <= ready_d;
      bit_q       <= bit_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  assign word_ready = ready_q;
  assign bit_out    = bit_q;
  assign bit_valid  = bit_valid_q;

endmodule

// File: rtl/config_chain_loader.sv
// Clears the tile configuration chain, then shifts exactly CHAIN_LENGTH bitstream bits into it
// while checking the chain return for continuity.
//   state | meaning
//   IDLE  | waiting for start; done/error hold the last load's result
//   CLEAR | config_nreset low for CLEAR_CYCLES cycles
//   LOAD  | words accepted and shifted until CHAIN_LENGTH bits are in
module config_chain_loader
  import config_loader_pkg::*;
#(
  parameter int CHAIN_LENGTH = DEF_CHAIN_LENGTH,
  parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
  parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  config_out,
  output logic                  config_enable,
  output logic                  config_nreset,
  input  logic                  chain_return,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam chain_geom_t GEOM = chain_geom(CHAIN_LENGTH, WORD_WIDTH);
  localparam int BW = $clog2(CHAIN_LENGTH + 1);
  localparam int KW = $clog2(CLEAR_CYCLES) + 1;
  localparam logic [BW-1:0] LAST_BIT   = BW'(CHAIN_LENGTH);
  localparam logic [KW-1:0] CLEAR_LOAD = KW'(CLEAR_CYCLES - 1);

  loader_state_t state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [KW-1:0] clr_cnt_q, clr_cnt_d;
  logic          nreset_q, nreset_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          shift_en;
  logic          shift_bit;

  config_word_serializer #(
    .WORD_WIDTH (WORD_WIDTH),
    .NUM_WORDS  (int'(GEOM.words)),
    .LAST_BITS  (int'(GEOM.last_bits))
  ) u_serializer (
    .clock      (clock),
    .reset      (reset),
    .active     (state_d == LOAD),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .bit_out    (shift_bit),
    .bit_valid  (shift_en)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    clr_cnt_d = clr_cnt_q;
    done_d    = done_q;
    error_d   = error_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CLEAR;
          clr_cnt_d = CLEAR_LOAD;
          done_d    = 1'b0;
          error_d   = 1'b0;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == '0) begin
          state_d   = LOAD;
          bit_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q - KW'(1);
        end
      end
      LOAD: begin
        if (shift_en && (bit_cnt_q != LAST_BIT)) bit_cnt_d = bit_cnt_q + BW'(1);
        // The chain was just cleared, so any 1 coming back during a shift is a break.
        if (shift_en && chain_return) error_d = 1'b1;
        if (bit_cnt_d == LAST_BIT) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d   = (state_d != IDLE);
    nreset_d = (state_d != CLEAR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      clr_cnt_q <= '0;
      nreset_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      clr_cnt_q <= clr_cnt_d;
      nreset_q  <= nreset_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign config_out    = shift_bit;
  assign config_enable = shift_en;
  assign config_nreset = nreset_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: doc/config_chain_loader.md
# config_chain_loader

Sequencer that loads a bitstream into the FPGA's daisy-chained tile configuration shift registers. It accepts parallel bitstream words from a host over a valid/ready port, clears the chain, and shifts exactly `CHAIN_LENGTH` bits into the first tile's `config_in`. It also checks the chain's return bit for continuity. It sits between the host/bootloader interface and the fabric's `config_*` pins. The tile config registers are clocked by the same `clock`.

## Interface
Parameters:
- `CHAIN_LENGTH`, 100: total configuration bits in the chain; must be at least 1.
- `WORD_WIDTH`, 8: bitstream word width.
- `CLEAR_CYCLES`, 2: number of cycles `config_nreset` is held low before loading; must be at least 1.

Ports:
- `clock`, in, 1: single clock. The fabric's `config_clock` is tied to it.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle request to begin a load. Ignored unless the block is in IDLE.
- `word_data`, in, `WORD_WIDTH`: bitstream word.
- `word_valid`, in, 1: host holds a word.
- `word_ready`, out, 1: the block accepts `word_data` this cycle.
- `config_out`, out, 1: serial data to the first tile's `config_in`.
- `config_enable`, out, 1: chain shift enable.
- `config_nreset`, out, 1: chain reset, active-low.
- `chain_return`, in, 1: last tile's `config_out`.
- `busy`, out, 1: the block is in CLEAR or LOAD.
- `done`, out, 1: sticky; the last load completed.
- `error`, out, 1: sticky; a continuity fault was seen during the last load.

## Operation
- States are IDLE, CLEAR and LOAD.
- IDLE:
  - `start` clears `done` and `error`, then moves to CLEAR.
- CLEAR:
  - `config_nreset`=0 for exactly `CLEAR_CYCLES` cycles; `config_enable`=0.
  - Then moves to LOAD with the bit counter at 0.
- LOAD, word handling:
  - The holding register takes a word on `word_valid && word_ready`.
  - Each word is shifted MSB first; words are shifted in arrival order.
- LOAD, shifting:
  - Each cycle that the holding register has a pending bit: `config_enable`=1, `config_out`=that bit, and the bit counter increments.
  - With no pending bit: `config_enable`=0, `config_out`=0, and the chain holds its contents.
- Word count and last word:
  - Words needed = ceil(`CHAIN_LENGTH`/`WORD_WIDTH`).
  - For the final word, only the top R bits are shifted, where R = `CHAIN_LENGTH` mod `WORD_WIDTH`. R=0 means a full word.
  - The unused LSBs of the final word are discarded.
- `word_ready` behaviour:
  - Asserted in LOAD when the holding register is empty, or is shifting its last bit, and fewer words than needed have been accepted.
  - A back-to-back valid stream therefore shifts continuously with no bubble.
- Continuity check:
  - CLEAR zeroes the chain, so `chain_return` must be 0 on every enabled shift of the load.
  - `chain_return`=1 while `config_enable`=1 sets `error`.
  - Loading continues after an error.
- Completion:
  - The cycle of the `CHAIN_LENGTH`-th shift is the last enabled cycle.
  - The next cycle sets `done`=1, clears `busy`, and enters IDLE.
- Boundaries:
  - Words beyond the needed count are never accepted, because `word_ready`=0.
  - `start` while `busy` is ignored.
  - `start` while `done`=1 begins a new load.
- Bit counter width: $clog2(`CHAIN_LENGTH`+1). The counter saturates at terminal; it never wraps.

## Timing
- Every output is registered.
- Reset values: `word_ready`=0, `config_out`=0, `config_enable`=0, `config_nreset`=0, `busy`=0, `done`=0, `error`=0.
- Reset while asserted, including mid-load:
  - The state is forced to IDLE.
  - The chain is held reset (`config_nreset`=0) and the partial word is discarded.
  - `config_nreset` returns to 1 on the first cycle after `reset` deasserts.
- Load sequence, with `start` sampled at cycle t:
  - `busy`=1 and `config_nreset`=0 from t+1 through t+`CLEAR_CYCLES`.
  - `word_ready` can rise at t+`CLEAR_CYCLES`+1.
- Shift latency: the first bit of a word accepted at cycle a appears on `config_out` with `config_enable`=1 at a+1.
- Minimum load time = `CLEAR_CYCLES` + `CHAIN_LENGTH` + 2 cycles after `start`, with the host always valid.
- `chain_return` is sampled in the same cycle as the `config_enable` it qualifies.

## Structure
- Package `config_loader_pkg` holds:
  - The state enum typedef `loader_state_t` (IDLE/CLEAR/LOAD).
  - Default parameter constants.
  - A function computing the words needed and the final-word bit count R.
- Sub-module `config_word_serializer`:
  - Contains the holding register, the per-word bit index, and the word-level ready/valid logic.
  - Outputs one bit per cycle plus a bit-valid signal.
  - The top level owns the FSM, the total bit counter, the continuity check and the status flags.

## Test plan
- Full load, defaults, host always valid, words 0xA5 repeated, `chain_return` tied 0:
  - Exactly 100 enabled shifts.
  - 13 words accepted; the last contributes 4 bits, 1010.
  - `done`=1 at `start`+104; `error`=0.
- Host stalls: drop `word_valid` for 3 cycles between words 5 and 6 -> `config_enable`=0 for those cycles, the bit sequence is unchanged, and `done` is delayed by 3 cycles.
- Stuck chain: `chain_return`=1 on the 37th enabled shift -> `error`=1 from the next cycle; the load still completes with `done`=1.
- Reset mid-load: assert `reset` after 50 shifts ->
  - All outputs take their reset values and the state is IDLE.
  - A subsequent `start` performs a full clear and a 100-bit load.
- `start` pulsed during CLEAR and LOAD -> ignored. `start` after `done` -> `done`/`error` clear and a new CLEAR of 2 cycles runs.
- `CHAIN_LENGTH`=16, `WORD_WIDTH`=8 -> exactly 2 words accepted, the final word is shifted in full, and `word_ready` never rises again.
